i2c_slave_regif: RTL and testbench
==================================

Name: i2c_slave_regif

Overview:
I2C target (slave) that sits directly downstream of the team's I2C master on the shared SCL/SDA bus. It oversamples SCL/SDA with the system clock, decodes START/STOP, matches a 7-bit device address and takes a register-pointer byte. It then performs byte writes to, or byte reads from, an external register bank through a simple synchronous register port. It drives SDA open-drain style through an output-enable: 1 pulls SDA low.

Parameters:
SLAVE_ADDR, 7'h50, 7-bit device address this target answers to
NUM_REGS, 16, number of addressable 8-bit registers; pointer width = $clog2(NUM_REGS)
SYNC_STAGES, 2, flip-flop stages on scl_in and sda_in (minimum 2)

Ports:
clk  input  1  system clock; must be at least 8x the SCL frequency
rst  input  1  asynchronous, active-high reset
scl_in  input  1  bus SCL, asynchronous
sda_in  input  1  bus SDA, asynchronous
sda_out_en  output  1  1 = pull SDA low (ACK or read data 0); 0 = release
reg_addr  output  $clog2(NUM_REGS)  current register pointer
reg_wr_en  output  1  one-cycle write strobe
reg_wr_data  output  8  write data, valid while reg_wr_en = 1
reg_rd_data  input  8  read data for reg_addr; sampled one clk after reg_addr changes
busy  output  1  1 from an address-matched START until STOP

Behaviour:
- Reset: sda_out_en=0, reg_wr_en=0, reg_addr=0, reg_wr_data=0, busy=0, state=IDLE, sync chains=1. Reset mid-transfer releases SDA immediately (asynchronous). After reset the block waits for the next START.
- Synchronisation: SYNC_STAGES flops, then a one-flop edge detector. Bus events are acted on SYNC_STAGES+1 clk after the pin changes.
- START = SDA fall while SCL high. STOP = SDA rise while SCL high. Both have priority over bit handling in any state.
- SDA is sampled on the detected SCL rise. sda_out_en changes only on the detected SCL fall.
- A 3-bit bit counter counts 0..7. Bytes are MSB first.
- States: IDLE, DEV_ADDR, DEV_ACK, REG_ADDR, REG_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK.
- IDLE: on START -> DEV_ADDR, bit counter cleared.
- DEV_ADDR: shift in 8 bits. If bits[7:1]==SLAVE_ADDR, assert busy and go to DEV_ACK: drive ACK (sda_out_en=1) for one SCL period. Otherwise go to IDLE and ignore the bus until the next START.
- After DEV_ACK:
  - R/W=0 -> REG_ADDR.
  - R/W=1 -> RD_DATA using the current pointer.
- REG_ADDR: shift in 8 bits.
  - Value < NUM_REGS: load reg_addr, ACK in REG_ACK, then -> WR_DATA.
  - Value >= NUM_REGS: NACK (sda_out_en stays 0) and -> IDLE.
- WR_DATA: shift in 8 bits. On the 8th rise, pulse reg_wr_en for exactly 1 clk with reg_wr_data = the byte. Then ACK in WR_ACK and return to WR_DATA for further bytes.
- RD_DATA:
  - Latch reg_rd_data on the SCL fall that enters the state.
  - Drive sda_out_en = ~bit for each bit, MSB first, on successive SCL falls.
  - Release SDA on the fall after bit 0, then -> RD_ACK.
- RD_ACK: sample the master's bit. ACK (0) -> next byte in RD_DATA. NACK (1) -> IDLE.
- STOP in any state: -> IDLE, busy=0, SDA released, pointer retained.
- Repeated START in any state: -> DEV_ADDR, busy=0 until the address matches again, pointer retained. This supports write-pointer-then-read.
- Simultaneous START detection and SCL rise cannot occur by construction (START requires SCL high). If STOP and a pending write strobe coincide, the strobe still issues.

Optional Feature:
Macro I2C_SLAVE_AUTOINC_EN.
- Defined: reg_addr increments after each written byte (at the reg_wr_en cycle) and after each read byte that the master ACKs. It wraps modulo NUM_REGS, so 15 -> 0 with the default.
- Undefined: reg_addr stays fixed for the whole transaction, and multi-byte accesses hit the same register.

Decomposition:
- Package i2c_pkg holds:
  - the enum i2c_slave_state_t
  - constants I2C_ACK=1'b0 and I2C_NACK=1'b1
- The master's enum may later move into the same package.
- Sub-module i2c_sync_edge (parameter STAGES) provides the synchroniser plus rise/fall pulses. It is instantiated once for SCL and once for SDA.

Test Plan:
- Write: START, 0xA0, reg 0x03, data 0x5A, STOP -> three ACKs; one reg_wr_en pulse with reg_addr=3, reg_wr_data=0x5A; busy falls at STOP.
- Read: write pointer 0x07, repeated START, 0xA1, reg_rd_data=0xC3, master NACK -> SDA carries 1100_0011; state IDLE after NACK.
- Address mismatch: START, 0xA2, data bytes -> sda_out_en never asserted; no reg_wr_en; busy=0.
- Out-of-range pointer: reg byte 0x10 with NUM_REGS=16 -> NACK at the 9th clock; no write occurs.
- Auto-increment (macro on): pointer 0x0F, write 0x11, 0x22 -> writes to addr 15 then 0; macro off -> both writes to 15.
- Reset mid-transfer: assert rst during the WR_DATA 4th bit -> sda_out_en=0 and busy=0 at once; the following full write of 0x99 to reg 1 completes normally.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM state encoding and bus ACK/NACK levels.
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_DEV_ADDR,
        ST_DEV_ACK,
        ST_REG_ADDR,
        ST_REG_ACK,
        ST_WR_DATA,
        ST_WR_ACK,
        ST_RD_DATA,
        ST_RD_ACK
    } i2c_slave_state_t;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

endpackage

// File: rtl/i2c_slave_regif_if.sv
// Bus pins and register-bank port of the I2C register target.
interface i2c_slave_regif_if #(
    parameter int NUM_REGS = 16
);
    localparam int PW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

    logic          scl_in;
    logic          sda_in;
    logic          sda_out_en;
    logic [PW-1:0] reg_addr;
    logic          reg_wr_en;
    logic [7:0]    reg_wr_data;
    logic [7:0]    reg_rd_data;
    logic          busy;

    modport slave (
        input  scl_in, sda_in, reg_rd_data,
        output sda_out_en, reg_addr, reg_wr_en, reg_wr_data, busy
    );

    modport master (
        output scl_in, sda_in, reg_rd_data,
        input  sda_out_en, reg_addr, reg_wr_en, reg_wr_data, busy
    );
endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchroniser for an asynchronous bus pin plus rise/fall pulses.
// Chain resets to 1 (idle bus level) so reset release does not fake a START.
module i2c_sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] sync;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1];
        end
    end

    assign q    = sync[STAGES-1];
    assign rise = q & ~prev;
    assign fall = ~q & prev;
endmodule

// File: rtl/i2c_slave_regif.sv
// I2C register target: address match, pointer byte, byte writes/reads to an external bank.
// Optional macro I2C_SLAVE_AUTOINC_EN: pointer advances after each written or master-ACKed read byte.
module i2c_slave_regif
    import i2c_pkg::*;
#(
    parameter logic [6:0] SLAVE_ADDR  = 7'h50,
    parameter int         NUM_REGS    = 16,
    parameter int         SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    i2c_slave_regif_if.slave bus
);
    localparam int         PW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [8:0] NREGS9 = 9'(NUM_REGS);

    localparam logic [3:0] IDLE     = ST_IDLE;
    localparam logic [3:0] DEV_ADDR = ST_DEV_ADDR;
    localparam logic [3:0] DEV_ACK  = ST_DEV_ACK;
    localparam logic [3:0] REG_ADDR = ST_REG_ADDR;
    localparam logic [3:0] REG_ACK  = ST_REG_ACK;
    localparam logic [3:0] WR_DATA  = ST_WR_DATA;
    localparam logic [3:0] WR_ACK   = ST_WR_ACK;
    localparam logic [3:0] RD_DATA  = ST_RD_DATA;
    localparam logic [3:0] RD_ACK   = ST_RD_ACK;

    logic scl_q, scl_rise, scl_fall;
    logic sda_q, sda_rise, sda_fall;

    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_scl (
        .clk(clk), .rst(rst), .d(bus.scl_in), .q(scl_q), .rise(scl_rise), .fall(scl_fall)
    );
    i2c_sync_edge #(.STAGES(SYNC_STAGES)) u_sda (
        .clk(clk), .rst(rst), .d(bus.sda_in), .q(sda_q), .rise(sda_rise), .fall(sda_fall)
    );

    logic [3:0]    state;
    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          rw;
    logic          late;     // ACK states: 9th rise seen; RD_DATA: 8th rise seen
    logic          sda_oe;
    logic          busy;
    logic [PW-1:0] reg_addr;
    logic          reg_wr_en;
    logic [7:0]    reg_wr_data;

    logic       start_det, stop_det, byte_last, addr_hit, reg_ok;
    logic [7:0] next_byte;

    assign start_det = sda_fall & scl_q;
    assign stop_det  = sda_rise & scl_q;
    assign next_byte = {shreg[6:0], sda_q};
    assign byte_last = (bit_cnt == 3'd7);
    assign addr_hit  = (next_byte[7:1] == SLAVE_ADDR);
    assign reg_ok    = ({1'b0, next_byte} < NREGS9);

`ifdef I2C_SLAVE_AUTOINC_EN
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NUM_REGS - 1)) ? '0 : p + 1'b1;
    endfunction
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shreg       <= '0;
            rw          <= 1'b0;
            late        <= 1'b0;
            sda_oe      <= 1'b0;
            busy        <= 1'b0;
            reg_addr    <= '0;
            reg_wr_en   <= 1'b0;
            reg_wr_data <= '0;
        end else begin
            reg_wr_en <= 1'b0;
`ifdef I2C_SLAVE_AUTOINC_EN
            // Advance at the end of the strobe cycle so the bank sees the written address.
            if (reg_wr_en) reg_addr <= ptr_inc(reg_addr);
`endif
            if (start_det) begin
                state   <= DEV_ADDR;
                bit_cnt <= '0;
                busy    <= 1'b0;
                sda_oe  <= 1'b0;
                late    <= 1'b0;
            end else if (stop_det) begin
                state  <= IDLE;
                busy   <= 1'b0;
                sda_oe <= 1'b0;
                late   <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    DEV_ADDR, REG_ADDR, WR_DATA: begin
                        shreg   <= next_byte;
                        bit_cnt <= bit_cnt + 1'b1;
                        late    <= 1'b0;
                        if (byte_last) begin
                            if (state == DEV_ADDR) begin
                                if (addr_hit) begin
                                    busy  <= 1'b1;
                                    rw    <= sda_q;
                                    state <= DEV_ACK;
                                end else begin
                                    state <= IDLE;
                                end
                            end else if (state == REG_ADDR) begin
                                if (reg_ok) begin
                                    reg_addr <= next_byte[PW-1:0];
                                    state    <= REG_ACK;
                                end else begin
                                    state <= IDLE;
                                end
                            end else begin
                                reg_wr_en   <= 1'b1;
                                reg_wr_data <= next_byte;
                                state       <= WR_ACK;
                            end
                        end
                    end
                    DEV_ACK, REG_ACK, WR_ACK: late <= 1'b1;
                    RD_DATA: begin
                        bit_cnt <= bit_cnt + 1'b1;
                        if (byte_last) late <= 1'b1;
                    end
                    RD_ACK: begin
                        if (sda_q == I2C_NACK) begin
                            state <= IDLE;
                        end else begin
                            late <= 1'b1;
`ifdef I2C_SLAVE_AUTOINC_EN
                            reg_addr <= ptr_inc(reg_addr);
`endif
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    DEV_ACK, REG_ACK, WR_ACK: begin
                        if (!late) begin
                            sda_oe <= ~I2C_ACK;
                        end else begin
                            late    <= 1'b0;
                            bit_cnt <= '0;
                            if (state == DEV_ACK && rw) begin
                                shreg  <= bus.reg_rd_data;
                                sda_oe <= ~bus.reg_rd_data[7];
                                state  <= RD_DATA;
                            end else begin
                                sda_oe <= 1'b0;
                                state  <= (state == DEV_ACK) ? REG_ADDR : WR_DATA;
                            end
                        end
                    end
                    RD_DATA: begin
                        if (late) begin
                            sda_oe <= 1'b0;
                            late   <= 1'b0;
                            state  <= RD_ACK;
                        end else begin
                            sda_oe <= ~shreg[6];
                            shreg  <= {shreg[6:0], 1'b0};
                        end
                    end
                    RD_ACK: begin
                        if (late) begin
                            late    <= 1'b0;
                            bit_cnt <= '0;
                            shreg   <= bus.reg_rd_data;
                            sda_oe  <= ~bus.reg_rd_data[7];
                            state   <= RD_DATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.sda_out_en  = sda_oe;
    assign bus.reg_addr    = reg_addr;
    assign bus.reg_wr_en   = reg_wr_en;
    assign bus.reg_wr_data = reg_wr_data;
    assign bus.busy        = busy;
endmodule

// File: tb/tb_i2c_slave_regif.sv
// Directed bench for i2c_slave_regif: table of write transactions plus read, auto-increment and reset sequences.
module tb_i2c_slave_regif;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl_m = 1'b1;
    logic sda_m = 1'b1;

    i2c_slave_regif_if #(.NUM_REGS(16)) bus ();

    i2c_slave_regif #(.SLAVE_ADDR(7'h50), .NUM_REGS(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    always #5 clk = ~clk;

    logic [7:0] rd_bank [16];
    assign bus.scl_in      = scl_m;
    assign bus.sda_in      = sda_m & ~bus.sda_out_en;
    assign bus.reg_rd_data = rd_bank[bus.reg_addr];

    int         wr_cnt = 0;
    int         oe_cnt = 0;
    int         wide_cnt = 0;
    logic       prev_we = 1'b0;
    logic [3:0] wr_addr [64];
    logic [7:0] wr_dat  [64];

    always @(negedge clk) begin
        if (bus.sda_out_en) oe_cnt++;
        if (bus.reg_wr_en) begin
            wr_addr[wr_cnt % 64] = bus.reg_addr;
            wr_dat[wr_cnt % 64]  = bus.reg_wr_data;
            wr_cnt++;
            if (prev_we) wide_cnt++;
        end
        prev_we = bus.reg_wr_en;
    end

    int n_vec = 0;
    int n_bad = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_q();
        repeat (10) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic bit_x(input logic b, output logic r);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q();
        r = bus.sda_in; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    // Master sends b, returns the bus byte seen and the 9th-clock level (0 = ACK).
    task automatic byte_w(input logic [7:0] b, output logic [7:0] r, output logic ack);
        logic t;
        for (int i = 7; i >= 0; i--) begin
            bit_x(b[i], t);
            r[i] = t;
        end
        bit_x(1'b1, ack);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] r);
        logic t;
        for (int i = 7; i >= 0; i--) begin
            bit_x(1'b1, t);
            r[i] = t;
        end
        bit_x(mack, t);
    endtask

    typedef struct {
        logic [7:0] dev;
        logic [7:0] rg;
        logic [7:0] dat;
        logic       ack_dev;
        logic       ack_reg;
        logic       ack_dat;
        logic       busy;
        int         nwr;
        logic [3:0] waddr;
        logic [7:0] wdata;
    } vec_t;

    vec_t tbl [6];

    initial begin
        logic [7:0] r, d0, d1;
        logic       a0, a1, a2, a3;
        int         wb, ob;
        logic [3:0] exp_a;

        for (int i = 0; i < 16; i++) rd_bank[i] = 8'(i * 17);
        rd_bank[7] = 8'hC3;
        rd_bank[8] = 8'h3C;

        tbl[0] = '{8'hA0, 8'h03, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1, 4'h3, 8'h5A};
        tbl[1] = '{8'hA0, 8'h0F, 8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1, 4'hF, 8'h11};
        tbl[2] = '{8'hA2, 8'h03, 8'h77, 1'b1, 1'b1, 1'b1, 1'b0, 0, 4'h0, 8'h00};
        tbl[3] = '{8'hA0, 8'h10, 8'h33, 1'b0, 1'b1, 1'b1, 1'b1, 0, 4'h0, 8'h00};
        tbl[4] = '{8'hA0, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1, 4'h0, 8'hFF};
        tbl[5] = '{8'hA0, 8'h0C, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1, 4'hC, 8'h00};

        // Reset state
        repeat (4) @(negedge clk);
        check("rst sda_out_en", 32'(bus.sda_out_en), 32'h0);
        check("rst reg_wr_en", 32'(bus.reg_wr_en), 32'h0);
        check("rst reg_addr", 32'(bus.reg_addr), 32'h0);
        check("rst reg_wr_data", 32'(bus.reg_wr_data), 32'h0);
        check("rst busy", 32'(bus.busy), 32'h0);
        rst = 1'b0;
        wait_q();

        // Single-byte write transactions
        for (int i = 0; i < 6; i++) begin
            wb = wr_cnt;
            ob = oe_cnt;
            i2c_start();
            byte_w(tbl[i].dev, r, a0);
            byte_w(tbl[i].rg, r, a1);
            byte_w(tbl[i].dat, r, a2);
            wait_q();
            check($sformatf("vec%0d dev_ack", i), 32'(a0), 32'(tbl[i].ack_dev));
            check($sformatf("vec%0d reg_ack", i), 32'(a1), 32'(tbl[i].ack_reg));
            check($sformatf("vec%0d dat_ack", i), 32'(a2), 32'(tbl[i].ack_dat));
            check($sformatf("vec%0d busy", i), 32'(bus.busy), 32'(tbl[i].busy));
            i2c_stop();
            wait_q();
            check($sformatf("vec%0d busy_after_stop", i), 32'(bus.busy), 32'h0);
            check($sformatf("vec%0d wr_count", i), 32'(wr_cnt - wb), 32'(tbl[i].nwr));
            check($sformatf("vec%0d oe_seen", i), 32'(oe_cnt != ob), 32'(!tbl[i].ack_dev));
            if (tbl[i].nwr > 0) begin
                check($sformatf("vec%0d wr_addr", i), 32'(wr_addr[wb % 64]), 32'(tbl[i].waddr));
                check($sformatf("vec%0d wr_data", i), 32'(wr_dat[wb % 64]), 32'(tbl[i].wdata));
            end
        end

        // Pointer write, repeated START, two-byte read (ACK then NACK)
        wb = wr_cnt;
        i2c_start();
        byte_w(8'hA0, r, a0);
        byte_w(8'h07, r, a1);
        i2c_start();
        byte_w(8'hA1, r, a2);
        read_byte(1'b0, d0);
        read_byte(1'b1, d1);
        check("rd dev_ack", 32'(a0), 32'h0);
        check("rd reg_ack", 32'(a1), 32'h0);
        check("rd rdev_ack", 32'(a2), 32'h0);
        check("rd byte0", 32'(d0), 32'hC3);
`ifdef I2C_SLAVE_AUTOINC_EN
        check("rd byte1", 32'(d1), 32'h3C);
        exp_a = 4'h8;
`else
        check("rd byte1", 32'(d1), 32'hC3);
        exp_a = 4'h7;
`endif
        // After NACK the target must be idle and leave the bus alone
        byte_w(8'hFF, r, a3);
        check("rd idle_data", 32'(r), 32'hFF);
        check("rd idle_ack", 32'(a3), 32'h1);
        check("rd busy_until_stop", 32'(bus.busy), 32'h1);
        i2c_stop();
        wait_q();
        check("rd busy_after_stop", 32'(bus.busy), 32'h0);
        check("rd ptr_retained", 32'(bus.reg_addr), 32'(exp_a));
        check("rd no_write", 32'(wr_cnt - wb), 32'h0);

        // Two-byte write at the top of the register range
        wb = wr_cnt;
        i2c_start();
        byte_w(8'hA0, r, a0);
        byte_w(8'h0F, r, a1);
        byte_w(8'h11, r, a2);
        byte_w(8'h22, r, a3);
        i2c_stop();
        wait_q();
        check("ai acks", 32'({a0, a1, a2, a3}), 32'h0);
        check("ai wr_count", 32'(wr_cnt - wb), 32'h2);
        check("ai wr0_addr", 32'(wr_addr[wb % 64]), 32'hF);
        check("ai wr0_data", 32'(wr_dat[wb % 64]), 32'h11);
        check("ai wr1_data", 32'(wr_dat[(wb + 1) % 64]), 32'h22);
`ifdef I2C_SLAVE_AUTOINC_EN
        check("ai wr1_addr", 32'(wr_addr[(wb + 1) % 64]), 32'h0);
        check("ai final_ptr", 32'(bus.reg_addr), 32'h1);
`else
        check("ai wr1_addr", 32'(wr_addr[(wb + 1) % 64]), 32'hF);
        check("ai final_ptr", 32'(bus.reg_addr), 32'hF);
`endif
        check("strobe_width", 32'(wide_cnt), 32'h0);

        // Reset while SCL is high on the 4th data bit
        wb = wr_cnt;
        i2c_start();
        byte_w(8'hA0, r, a0);
        byte_w(8'h01, r, a1);
        bit_x(1'b1, a2);
        bit_x(1'b0, a2);
        bit_x(1'b0, a2);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1;
        repeat (5) @(negedge clk);
        check("mid busy_before_rst", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        #1;
        check("mid rst sda_out_en", 32'(bus.sda_out_en), 32'h0);
        check("mid rst busy", 32'(bus.busy), 32'h0);
        check("mid rst reg_addr", 32'(bus.reg_addr), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wait_q();
        scl_m = 1'b0; wait_q();
        sda_m = 1'b1; wait_q();
        check("mid no_write", 32'(wr_cnt - wb), 32'h0);

        wb = wr_cnt;
        i2c_start();
        byte_w(8'hA0, r, a0);
        byte_w(8'h01, r, a1);
        byte_w(8'h99, r, a2);
        i2c_stop();
        wait_q();
        check("post acks", 32'({a0, a1, a2}), 32'h0);
        check("post wr_count", 32'(wr_cnt - wb), 32'h1);
        check("post wr_addr", 32'(wr_addr[wb % 64]), 32'h1);
        check("post wr_data", 32'(wr_dat[wb % 64]), 32'h99);
        check("post busy", 32'(bus.busy), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
